// File: rtl/tiny_eth_pkg.sv
// Shared types and constants for the tiny Ethernet MAC (transmit and receive paths).
package tiny_eth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        DATA,
        PAD,
        FCS,
        DROP,
        IFG
    } mac_tx_state_t;

    localparam logic [3:0]  ETH_PREAMBLE_NIB = 4'h5;
    localparam logic [3:0]  ETH_SFD_HI_NIB   = 4'hD;
    localparam logic [31:0] ETH_CRC_POLY     = 32'hEDB88320;
    localparam logic [31:0] ETH_CRC_INIT     = 32'hFFFFFFFF;
    localparam logic [31:0] ETH_CRC_RESIDUE  = 32'hDEBB20E3;

    // One reflected CRC-32 step over a nibble, LSB first.
    function automatic logic [31:0] crc32_nib_step(input logic [31:0] crc, input logic [3:0] nib);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 4; i++) begin
            if (c[0] ^ nib[i]) c = (c >> 1) ^ ETH_CRC_POLY;
            else               c = c >> 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/tiny_eth_crc32_nib.sv
// Nibble-serial CRC-32 register; crc_next exposes the value the register takes at the next edge.
module tiny_eth_crc32_nib
    import tiny_eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic [3:0]  nib,
    output logic [31:0] crc,
    output logic [31:0] crc_next
);

    // Init has priority over an update in the same cycle.
    always_comb begin
        crc_next = crc;
        if (init)    crc_next = ETH_CRC_INIT;
        else if (en) crc_next = crc32_nib_step(crc, nib);
    end

    // CRC state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) crc <= ETH_CRC_INIT;
        else      crc <= crc_next;
    end

endmodule

// File: rtl/tiny_eth_mac_tx.sv
// MII transmit path: preamble/SFD, nibble-serial data, zero padding, FCS and inter-frame gap.
module tiny_eth_mac_tx
    import tiny_eth_pkg::*;
#(
    parameter int MIN_FRAME   = 60,
    parameter int IFG_NIBBLES = 24
) (
    input  logic       tx_clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [3:0] tx_data,
    output logic       tx_en,
    output logic       busy,
    output logic       underrun
);

    localparam logic [10:0] MIN_CNT  = 11'(MIN_FRAME);
    localparam logic [15:0] IFG_LAST = 16'(IFG_NIBBLES - 1);

    mac_tx_state_t state;
    logic [15:0]   nib_cnt;
    logic          hi_phase;
    logic          last_byte;
    logic [10:0]   byte_cnt;
    logic [3:0]    byte_hi;
    logic          take;
    logic          starve;
    logic          crc_init;
    logic          crc_en;
    logic [31:0]   crc_q;
    logic [31:0]   crc_next;

    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    function automatic logic [3:0] fcs_nib(input logic [31:0] c, input logic [2:0] idx);
        logic [31:0] inv;
        inv = ~c;
        return inv[{idx, 2'b00} +: 4];
    endfunction

    // s_ready is only raised in PREAMBLE (SFD cycle) and DATA (high nibble); the CRC
    // follows the nibble currently on tx_data so crc_next already covers it.
    always_comb begin
        take     = s_ready &&  s_valid && (state == PREAMBLE || state == DATA);
        starve   = s_ready && !s_valid && (state == PREAMBLE || state == DATA);
        crc_init = (state == PREAMBLE);
        crc_en   = (state == DATA) || (state == PAD);
    end

    tiny_eth_crc32_nib u_crc (
        .clk      (tx_clk),
        .rst      (rst),
        .init     (crc_init),
        .en       (crc_en),
        .nib      (tx_data),
        .crc      (crc_q),
        .crc_next (crc_next)
    );

    // Upper nibble of the accepted byte, sent in the following cycle.
    always_ff @(posedge tx_clk) begin
        if (take) byte_hi <= s_data[7:4];
    end

    // Transmit FSM; every output is registered here and reflects the current state.
    always_ff @(posedge tx_clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            nib_cnt   <= '0;
            hi_phase  <= 1'b0;
            last_byte <= 1'b0;
            byte_cnt  <= '0;
            s_ready   <= 1'b0;
            tx_data   <= '0;
            tx_en     <= 1'b0;
            busy      <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (take) begin
                state     <= DATA;
                last_byte <= s_last;
                hi_phase  <= 1'b0;
                tx_data   <= s_data[3:0];
                s_ready   <= 1'b0;
                byte_cnt  <= (state == PREAMBLE) ? 11'd1 : sat_inc(byte_cnt);
            end else if (starve) begin
                // Abort the frame on the wire; the rest of it is swallowed in DROP.
                state    <= DROP;
                tx_en    <= 1'b0;
                tx_data  <= '0;
                underrun <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (s_valid) begin
                            state   <= PREAMBLE;
                            tx_en   <= 1'b1;
                            tx_data <= ETH_PREAMBLE_NIB;
                            busy    <= 1'b1;
                            nib_cnt <= '0;
                        end
                    end
                    PREAMBLE: begin
                        nib_cnt <= nib_cnt + 16'd1;
                        tx_data <= (nib_cnt == 16'd14) ? ETH_SFD_HI_NIB : ETH_PREAMBLE_NIB;
                        s_ready <= (nib_cnt == 16'd14);
                    end
                    DATA: begin
                        if (!hi_phase) begin
                            hi_phase <= 1'b1;
                            tx_data  <= byte_hi;
                            s_ready  <= !last_byte;
                        end else if (byte_cnt < MIN_CNT) begin
                            state    <= PAD;
                            hi_phase <= 1'b0;
                            tx_data  <= '0;
                            byte_cnt <= sat_inc(byte_cnt);
                        end else begin
                            state   <= FCS;
                            tx_data <= fcs_nib(crc_next, 3'd0);
                            nib_cnt <= '0;
                        end
                    end
                    PAD: begin
                        if (!hi_phase) begin
                            hi_phase <= 1'b1;
                            tx_data  <= '0;
                        end else if (byte_cnt >= MIN_CNT) begin
                            state   <= FCS;
                            tx_data <= fcs_nib(crc_next, 3'd0);
                            nib_cnt <= '0;
                        end else begin
                            hi_phase <= 1'b0;
                            tx_data  <= '0;
                            byte_cnt <= sat_inc(byte_cnt);
                        end
                    end
                    FCS: begin
                        if (nib_cnt == 16'd7) begin
                            state   <= IFG;
                            tx_en   <= 1'b0;
                            tx_data <= '0;
                            nib_cnt <= '0;
                        end else begin
                            nib_cnt <= nib_cnt + 16'd1;
                            tx_data <= fcs_nib(crc_q, nib_cnt[2:0] + 3'd1);
                        end
                    end
                    DROP: begin
                        if (s_valid && s_last) begin
                            state   <= IFG;
                            s_ready <= 1'b0;
                            nib_cnt <= '0;
                        end
                    end
                    IFG: begin
                        if (nib_cnt == IFG_LAST) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            nib_cnt <= nib_cnt + 16'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tiny_eth_mac_tx.sv
// Scoreboard bench for tiny_eth_mac_tx: one instance without padding, one with default parameters.
module tb_tiny_eth_mac_tx;

    localparam int          IFG     = 24;
    localparam logic [31:0] POLY    = 32'hEDB88320;
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

    logic       tx_clk = 1'b0;
    logic       rst;
    logic [7:0] sd [2];
    logic       sv [2];
    logic       sl [2];
    logic       sr [2];
    logic [3:0] td [2];
    logic       te [2];
    logic       bz [2];
    logic       ur [2];

    logic [3:0] exp_nib [2][$];
    int         exp_len [2][$];
    bit         exp_res [2][$];
    int         exp_gap [2][$];

    int checks = 0;
    int errors = 0;
    int urun_cnt [2];
    int run_len_g [2];

    always #5 tx_clk = ~tx_clk;

    tiny_eth_mac_tx #(.MIN_FRAME(0), .IFG_NIBBLES(IFG)) u_dut0 (
        .tx_clk(tx_clk), .rst(rst), .s_data(sd[0]), .s_valid(sv[0]), .s_last(sl[0]),
        .s_ready(sr[0]), .tx_data(td[0]), .tx_en(te[0]), .busy(bz[0]), .underrun(ur[0])
    );

    tiny_eth_mac_tx u_dut (
        .tx_clk(tx_clk), .rst(rst), .s_data(sd[1]), .s_valid(sv[1]), .s_last(sl[1]),
        .s_ready(sr[1]), .tx_data(td[1]), .tx_en(te[1]), .busy(bz[1]), .underrun(ur[1])
    );

    function automatic logic [31:0] nib_step(input logic [31:0] c, input logic [3:0] n);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 4; i++) r = ((r[0] ^ n[i]) != 1'b0) ? ((r >> 1) ^ POLY) : (r >> 1);
        return r;
    endfunction

    // Bytewise reference FCS (already inverted) over the frame padded to min_len.
    function automatic logic [31:0] model_fcs(input logic [7:0] b[$], input int min_len);
        logic [31:0] c;
        int          tot;
        logic [7:0]  v;
        c   = 32'hFFFFFFFF;
        tot = (b.size() > min_len) ? b.size() : min_len;
        for (int i = 0; i < tot; i++) begin
            v = (i < b.size()) ? b[i] : 8'h00;
            c = c ^ {24'd0, v};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    task automatic push_frame(input int sel, input logic [7:0] b[$], input int n_emit,
                              input bit full, input logic [31:0] fcs_fixed, input bit use_fixed);
        int          minl;
        int          tot;
        logic [31:0] f;
        for (int i = 0; i < 15; i++) exp_nib[sel].push_back(4'h5);
        exp_nib[sel].push_back(4'hD);
        for (int i = 0; i < n_emit; i++) begin
            exp_nib[sel].push_back(b[i][3:0]);
            exp_nib[sel].push_back(b[i][7:4]);
        end
        if (full) begin
            minl = (sel == 0) ? 0 : 60;
            tot  = (n_emit > minl) ? n_emit : minl;
            for (int i = n_emit; i < tot; i++) begin
                exp_nib[sel].push_back(4'h0);
                exp_nib[sel].push_back(4'h0);
            end
            f = use_fixed ? fcs_fixed : model_fcs(b, minl);
            for (int k = 0; k < 8; k++) exp_nib[sel].push_back(f[4*k +: 4]);
            exp_len[sel].push_back(16 + 2*tot + 8);
            exp_res[sel].push_back(1'b1);
        end else begin
            exp_len[sel].push_back(16 + 2*n_emit);
            exp_res[sel].push_back(1'b0);
        end
    endtask

    task automatic wait_ready(input int sel);
        int k;
        k = 0;
        do begin
            @(negedge tx_clk);
            k++;
        end while (!sr[sel] && k < 5000);
        checks++;
        if (!sr[sel]) begin
            errors++;
            $display("FAIL s_ready_timeout[%0d]: got 0 after %0d cycles, expected 1", sel, k);
        end
    endtask

    task automatic send_frame(input int sel, input logic [7:0] b[$], input int gap_at, input bit hold);
        for (int i = 0; i < b.size(); i++) begin
            if (i == gap_at) begin
                sv[sel] = 1'b0;
                wait_ready(sel);
                @(posedge tx_clk);
                #1;
            end
            sd[sel] = b[i];
            sl[sel] = (i == b.size() - 1);
            sv[sel] = 1'b1;
            wait_ready(sel);
            @(posedge tx_clk);
            #1;
        end
        if (!hold) begin
            sv[sel] = 1'b0;
            sl[sel] = 1'b0;
        end
    endtask

    task automatic wait_idle(input int sel);
        int k;
        k = 0;
        do begin
            @(negedge tx_clk);
            k++;
        end while ((bz[sel] || exp_nib[sel].size() != 0) && k < 10000);
        checks++;
        if (bz[sel] || exp_nib[sel].size() != 0) begin
            errors++;
            $display("FAIL idle_timeout[%0d]: busy=%0d pending=%0d, expected idle", sel, bz[sel], exp_nib[sel].size());
        end
    endtask

    // Monitors: compare every transmitted nibble, frame length, FCS residue and gap length.
    for (genvar g = 0; g < 2; g++) begin : g_mon
        int          run_len;
        int          low_len;
        int          eg;
        int          el;
        bit          er;
        bit          prev_rdy;
        logic        prev_en;
        logic [3:0]  en_nib;
        logic [31:0] mcrc;

        initial begin
            run_len = 0; low_len = 0; prev_rdy = 1'b0; prev_en = 1'b0; mcrc = '1;
        end

        always @(negedge tx_clk) begin
            if (!rst) begin
                run_len = 0; low_len = 0; prev_rdy = 1'b0; prev_en = 1'b0;
                run_len_g[g] = 0;
            end else begin
                if (ur[g]) urun_cnt[g]++;
                if (te[g]) begin
                    if (!prev_en) begin
                        if (exp_gap[g].size() > 0) begin
                            eg = exp_gap[g].pop_front();
                            checks++;
                            if (low_len != eg) begin
                                errors++;
                                $display("FAIL gap[%0d]: low cycles %0d, expected %0d", g, low_len, eg);
                            end
                        end
                        run_len = 0;
                        mcrc = '1;
                    end
                    run_len++;
                    run_len_g[g] = run_len;
                    checks++;
                    if (exp_nib[g].size() == 0) begin
                        errors++;
                        $display("FAIL nibble[%0d]: got %h at cycle %0d, expected no transmission", g, td[g], run_len);
                    end else begin
                        en_nib = exp_nib[g].pop_front();
                        if (td[g] !== en_nib) begin
                            errors++;
                            $display("FAIL nibble[%0d]: got %h at cycle %0d, expected %h", g, td[g], run_len, en_nib);
                        end
                    end
                    if (run_len > 16) mcrc = nib_step(mcrc, td[g]);
                    if (sr[g]) begin
                        checks++;
                        if (prev_rdy) begin
                            errors++;
                            $display("FAIL ready_twice[%0d]: s_ready high two cycles at %0d, expected single pulse", g, run_len);
                        end
                    end
                    prev_rdy = sr[g];
                end else begin
                    if (prev_en) begin
                        checks++;
                        if (exp_len[g].size() == 0) begin
                            errors++;
                            $display("FAIL length[%0d]: got %0d, expected no frame", g, run_len);
                        end else begin
                            el = exp_len[g].pop_front();
                            er = exp_res[g].pop_front();
                            if (run_len != el) begin
                                errors++;
                                $display("FAIL length[%0d]: tx_en high %0d, expected %0d", g, run_len, el);
                            end
                            if (er) begin
                                checks++;
                                if (mcrc !== RESIDUE) begin
                                    errors++;
                                    $display("FAIL residue[%0d]: got %h, expected %h", g, mcrc, RESIDUE);
                                end
                            end
                        end
                        low_len = 0;
                        run_len_g[g] = 0;
                    end
                    low_len++;
                    prev_rdy = 1'b0;
                    checks++;
                    if (td[g] !== 4'h0) begin
                        errors++;
                        $display("FAIL idle_data[%0d]: got %h with tx_en low, expected 0", g, td[g]);
                    end
                end
                prev_en = te[g];
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] fr[$];
        logic [7:0] fb[$];
        int         k;

        rst = 1'b0;
        urun_cnt[0] = 0; urun_cnt[1] = 0;
        run_len_g[0] = 0; run_len_g[1] = 0;
        for (int s = 0; s < 2; s++) begin
            sv[s] = 1'b0; sl[s] = 1'b0; sd[s] = 8'h00;
        end
        #23;
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("reset tx_en[%0d]", s),    {31'd0, te[s]}, 32'd0);
            chk($sformatf("reset s_ready[%0d]", s),  {31'd0, sr[s]}, 32'd0);
            chk($sformatf("reset busy[%0d]", s),     {31'd0, bz[s]}, 32'd0);
            chk($sformatf("reset underrun[%0d]", s), {31'd0, ur[s]}, 32'd0);
            chk($sformatf("reset tx_data[%0d]", s),  {28'd0, td[s]}, 32'd0);
        end
        @(posedge tx_clk);
        #2 rst = 1'b1;
        @(negedge tx_clk);
        chk("post-reset busy", {31'd0, bz[1]}, 32'd0);

        // "123456789" without padding: FCS is the well-known check value.
        fr.delete();
        for (int i = 0; i < 9; i++) fr.push_back(8'h31 + 8'(i));
        push_frame(0, fr, 9, 1'b1, 32'hCBF43926, 1'b1);
        send_frame(0, fr, -1, 1'b0);
        wait_idle(0);

        // Short frame, padded to 60 bytes.
        fr.delete();
        for (int i = 0; i < 14; i++) fr.push_back(8'((i * 29 + 3) & 255));
        push_frame(1, fr, 14, 1'b1, 32'd0, 1'b0);
        send_frame(1, fr, -1, 1'b0);
        wait_idle(1);

        // Two 64-byte frames with s_valid held high in between.
        fr.delete();
        fb.delete();
        for (int i = 0; i < 64; i++) fr.push_back(8'((i * 37 + 11) & 255));
        for (int i = 0; i < 64; i++) fb.push_back(8'((i * 53 + 200) & 255));
        push_frame(1, fr, 64, 1'b1, 32'd0, 1'b0);
        send_frame(1, fr, -1, 1'b1);
        exp_gap[1].push_back(IFG + 1);
        push_frame(1, fb, 64, 1'b1, 32'd0, 1'b0);
        send_frame(1, fb, -1, 1'b0);
        wait_idle(1);

        // Underrun at byte 20, then a normal frame.
        fr.delete();
        for (int i = 0; i < 64; i++) fr.push_back(8'((i * 7 + 90) & 255));
        push_frame(1, fr, 20, 1'b0, 32'd0, 1'b0);
        send_frame(1, fr, 20, 1'b0);
        wait_idle(1);
        chk("underrun pulses", urun_cnt[1], 32'd1);
        fr.delete();
        for (int i = 0; i < 20; i++) fr.push_back(8'((i * 91 + 17) & 255));
        push_frame(1, fr, 20, 1'b1, 32'd0, 1'b0);
        send_frame(1, fr, -1, 1'b0);
        wait_idle(1);

        // Reset in the middle of the FCS.
        fr.delete();
        for (int i = 0; i < 14; i++) fr.push_back(8'((i * 13 + 1) & 255));
        push_frame(1, fr, 14, 1'b1, 32'd0, 1'b0);
        send_frame(1, fr, -1, 1'b0);
        k = 0;
        while (run_len_g[1] < 140 && k < 2000) begin
            @(negedge tx_clk);
            k++;
        end
        chk("reach FCS", {31'd0, (run_len_g[1] >= 140)}, 32'd1);
        #3 rst = 1'b0;
        #1;
        chk("async rst tx_en",   {31'd0, te[1]}, 32'd0);
        chk("async rst s_ready", {31'd0, sr[1]}, 32'd0);
        chk("async rst busy",    {31'd0, bz[1]}, 32'd0);
        chk("async rst tx_data", {28'd0, td[1]}, 32'd0);
        exp_nib[1].delete();
        exp_len[1].delete();
        exp_res[1].delete();
        repeat (3) @(posedge tx_clk);
        #2 rst = 1'b1;
        @(negedge tx_clk);
        chk("after release busy", {31'd0, bz[1]}, 32'd0);
        fr.delete();
        for (int i = 0; i < 30; i++) fr.push_back(8'((i * 45 + 77) & 255));
        push_frame(1, fr, 30, 1'b1, 32'd0, 1'b0);
        send_frame(1, fr, -1, 1'b0);
        wait_idle(1);

        // Long frame: no padding, FCS over all 1600 bytes.
        fr.delete();
        for (int i = 0; i < 1600; i++) fr.push_back(8'((i * 101 + (i >> 8)) & 255));
        push_frame(1, fr, 1600, 1'b1, 32'd0, 1'b0);
        send_frame(1, fr, -1, 1'b0);
        wait_idle(1);

        chk("no underrun dut0", urun_cnt[0], 32'd0);
        chk("underrun total",   urun_cnt[1], 32'd1);
        chk("pending lengths",  exp_len[1].size(), 32'd0);
        chk("pending dut0",     exp_len[0].size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
